// File: rtl/mem_block_engine_pkg.sv
// Shared definitions for the block copy/fill memory engine.
// State encodings and operation selectors used by the engine and its pointer helper.
package mem_block_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

endpackage

// File: rtl/mem_block_engine_addr_ptr.sv
// Address pointer: loads a base address and increments with natural wrap
// modulo 2**W, so blocks that run off the top of memory continue at 0.
module mem_block_engine_addr_ptr #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/mem_block_engine.sv
// Bus-master engine that copies or fills a block of the single-port data memory.
// All memory-port outputs decode from registered state, never from start.
module mem_block_engine
  import mem_block_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_fill,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] fill_val,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_op_fill;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] r_fill_val;
  logic [ADDR_WIDTH-1:0] w_src_ptr;
  logic [ADDR_WIDTH-1:0] w_dst_ptr;
  logic                  w_take;

  // start only matters in IDLE; anything arriving later is dropped
  assign w_take = (r_state == ST_IDLE) && start;

  mem_block_engine_addr_ptr #(.W(ADDR_WIDTH)) u_src_ptr (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_take),
    .i_load_val (src_addr),
    .i_inc      (r_state == ST_RD),
    .o_ptr      (w_src_ptr)
  );

  mem_block_engine_addr_ptr #(.W(ADDR_WIDTH)) u_dst_ptr (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_take),
    .i_load_val (dst_addr),
    .i_inc      (r_state == ST_WR),
    .o_ptr      (w_dst_ptr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op_fill  <= 1'b0;
      r_count    <= '0;
      r_buf      <= '0;
      r_fill_val <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_op_fill  <= op_fill;
        r_count    <= length;
        r_fill_val <= fill_val;
      end
      if (r_state == ST_RD) begin
        r_buf <= mem_q;
      end
      if (r_state == ST_WR) begin
        r_count <= r_count - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (length == '0)             w_state_next = ST_FIN;
          else if (op_fill == OP_FILL)  w_state_next = ST_WR;
          else                          w_state_next = ST_RD;
        end
      end
      ST_RD:   w_state_next = ST_WR;
      ST_WR: begin
        if (r_count == (ADDR_WIDTH+1)'(1)) w_state_next = ST_FIN;
        else if (r_op_fill == OP_FILL)     w_state_next = ST_WR;
        else                               w_state_next = ST_RD;
      end
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    unique case (r_state)
      ST_RD: begin
        busy     = 1'b1;
        mem_addr = w_src_ptr;
      end
      ST_WR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = w_dst_ptr;
        mem_data = (r_op_fill == OP_COPY) ? r_buf : r_fill_val;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_block_engine.sv
// Directed bench for mem_block_engine with a behavioural single-port memory
// (combinational read, write on rising edge) and a backdoor preload path.
module tb_mem_block_engine;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          op_fill;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   length;
  logic [DW-1:0] fill_val;
  logic          busy;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_clr;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic          cnt_clr;
  int            we_cnt;
  int            done_cnt;
  int            busy_cnt;
  logic [AW-1:0] wr_log [0:15];

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clock = ~clock;

  mem_block_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op_fill  (op_fill),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_q    (mem_q)
  );

  assign mem_q = mem[mem_addr];

  always @(posedge clock) begin
    if (bd_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  // activity monitor over the cycle that just ended
  always @(posedge clock) begin
    if (cnt_clr) begin
      we_cnt   <= 0;
      done_cnt <= 0;
      busy_cnt <= 0;
    end else begin
      if (mem_we) begin
        if (we_cnt < 16) wr_log[we_cnt[3:0]] <= mem_addr;
        we_cnt <= we_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clock);
    bd_we   = 1'b0;
  endtask

  // counters are cleared, start pulses for one cycle, lat = cycles from start to done
  task automatic run_op(input logic f, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [AW:0] n, input logic [DW-1:0] v, output int l);
    cnt_clr = 1'b1;
    @(negedge clock);
    cnt_clr  = 1'b0;
    op_fill  = f;
    src_addr = s;
    dst_addr = d;
    length   = n;
    fill_val = v;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    l = 1;
    while (!done && l < 200) begin
      @(negedge clock);
      l++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done");
    end
    @(negedge clock);
    check("done_one_cyc", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_fill = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_val = '0; bd_clr = 1'b1; bd_we = 1'b0; bd_addr = '0;
    bd_data = '0; cnt_clr = 1'b1;
    repeat (2) @(negedge clock);
    bd_clr = 1'b0;
    reset  = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we",   {31'd0, mem_we}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);

    // copy 0..3 -> 16..19
    bd_write(6'd0, 8'h11); bd_write(6'd1, 8'h22); bd_write(6'd2, 8'h33); bd_write(6'd3, 8'h44);
    run_op(1'b0, 6'd0, 6'd16, 7'd4, 8'h00, lat);
    check("copy_lat", 32'(lat), 32'd9);
    check("copy_we_cnt", 32'(we_cnt), 32'd4);
    check("copy_done_cnt", 32'(done_cnt), 32'd1);
    check("copy_d16", 32'(mem[16]), 32'h11);
    check("copy_d17", 32'(mem[17]), 32'h22);
    check("copy_d18", 32'(mem[18]), 32'h33);
    check("copy_d19", 32'(mem[19]), 32'h44);
    check("copy_s0", 32'(mem[0]), 32'h11);
    check("copy_s3", 32'(mem[3]), 32'h44);

    // fill with wrap at top of memory
    run_op(1'b1, 6'd0, 6'd62, 7'd4, 8'hA5, lat);
    check("fill_lat", 32'(lat), 32'd5);
    check("fill_we_cnt", 32'(we_cnt), 32'd4);
    check("fill_a0", 32'(wr_log[0]), 32'd62);
    check("fill_a1", 32'(wr_log[1]), 32'd63);
    check("fill_a2", 32'(wr_log[2]), 32'd0);
    check("fill_a3", 32'(wr_log[3]), 32'd1);
    check("fill_m62", 32'(mem[62]), 32'hA5);
    check("fill_m63", 32'(mem[63]), 32'hA5);
    check("fill_m0", 32'(mem[0]), 32'hA5);
    check("fill_m1", 32'(mem[1]), 32'hA5);
    check("fill_m2", 32'(mem[2]), 32'h33);

    // zero length
    run_op(1'b0, 6'd5, 6'd20, 7'd0, 8'h00, lat);
    check("zero_lat", 32'(lat), 32'd1);
    check("zero_busy", 32'(busy_cnt), 32'd0);
    check("zero_we", 32'(we_cnt), 32'd0);

    // overlapping forward copy propagates the first word
    bd_write(6'd8, 8'h07); bd_write(6'd9, 8'h01);
    run_op(1'b0, 6'd8, 6'd9, 7'd3, 8'h00, lat);
    check("ovl_lat", 32'(lat), 32'd7);
    check("ovl_m9", 32'(mem[9]), 32'h07);
    check("ovl_m10", 32'(mem[10]), 32'h07);
    check("ovl_m11", 32'(mem[11]), 32'h07);

    // second start during a busy copy must be ignored
    bd_write(6'd0, 8'h11); bd_write(6'd1, 8'h22);
    cnt_clr = 1'b1;
    @(negedge clock);
    cnt_clr = 1'b0; op_fill = 1'b0; src_addr = 6'd0; dst_addr = 6'd32; length = 7'd4;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("bsy_rd_addr", 32'(mem_addr), 32'd0);
    check("bsy_rd_we", {31'd0, mem_we}, 32'd0);
    @(negedge clock);
    check("bsy_wr_we", {31'd0, mem_we}, 32'd1);
    check("bsy_wr_addr", 32'(mem_addr), 32'd32);
    check("bsy_wr_data", 32'(mem_data), 32'h11);
    @(negedge clock);
    dst_addr = 6'd40; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    repeat (4) @(negedge clock);
    check("bsy_lat", 32'(lat), 32'd9);
    check("bsy_done_cnt", 32'(done_cnt), 32'd1);
    check("bsy_we_cnt", 32'(we_cnt), 32'd4);
    check("bsy_m32", 32'(mem[32]), 32'h11);
    check("bsy_m35", 32'(mem[35]), 32'h44);
    check("bsy_m40", 32'(mem[40]), 32'h00);

    // reset during the third write of a length-8 fill
    cnt_clr = 1'b1;
    @(negedge clock);
    cnt_clr = 1'b0; op_fill = 1'b1; dst_addr = 6'd48; length = 7'd8; fill_val = 8'h5A;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rmid_busy", {31'd0, busy}, 32'd0);
    check("rmid_we", {31'd0, mem_we}, 32'd0);
    check("rmid_done", {31'd0, done}, 32'd0);
    repeat (4) @(negedge clock);
    check("rmid_done_cnt", 32'(done_cnt), 32'd0);
    check("rmid_we_le3", {31'd0, (we_cnt <= 3)}, 32'd1);
    check("rmid_m48", 32'(mem[48]), 32'h5A);
    check("rmid_m51", 32'(mem[51]), 32'h00);
    run_op(1'b1, 6'd0, 6'd48, 7'd2, 8'hC3, lat);
    check("rnew_lat", 32'(lat), 32'd3);
    check("rnew_m48", 32'(mem[48]), 32'hC3);
    check("rnew_m49", 32'(mem[49]), 32'hC3);

    // full-memory fill
    run_op(1'b1, 6'd0, 6'd5, 7'd64, 8'h77, lat);
    check("full_lat", 32'(lat), 32'd65);
    check("full_we_cnt", 32'(we_cnt), 32'd64);
    check("full_m4", 32'(mem[4]), 32'h77);
    check("full_m5", 32'(mem[5]), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_block_engine.md
Name: mem_block_engine

Overview:
- Bus-master block that drives the data memory's single-port interface (clock, we, addr, data, q) to perform block copy or block fill operations without CPU involvement.
- Sits beside the Simple Computer datapath. While busy it is the sole driver of the memory port; the top-level mux selects it whenever busy=1.
- Timing assumptions about the memory:
  - reads are combinational from the address;
  - writes commit on the rising clock edge when we=1.

Parameters:
- ADDR_WIDTH, 6: memory address width; must match the data memory.
- DATA_WIDTH, 8: memory word width.

Ports:
- clock      input   1             system clock; all state updates on the rising edge
- reset      input   1             synchronous, active-high reset
- start      input   1             single-cycle request; sampled only in IDLE
- op_fill    input   1             0 = copy src->dst, 1 = fill dst with fill_val
- src_addr   input   ADDR_WIDTH    copy source base address
- dst_addr   input   ADDR_WIDTH    destination base address
- length     input   ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
- fill_val   input   DATA_WIDTH    fill constant
- busy       output  1             high in RD or WR states
- done       output  1             one-cycle pulse when the operation completes
- mem_we     output  1             memory write enable
- mem_addr   output  ADDR_WIDTH    memory address
- mem_data   output  DATA_WIDTH    memory write data
- mem_q      input   DATA_WIDTH    memory read data (combinational)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state: IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_data=0; internal src/dst pointers, count and buffer all cleared.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - on start=1, latch op_fill, src_addr, dst_addr, length and fill_val into registers. Later input changes are ignored.
  - if length=0, go to FIN;
  - else if op_fill=1, go to WR;
  - else go to RD.
- RD (copy only):
  - mem_addr=src_ptr, mem_we=0;
  - mem_q is captured into buf at the clock edge;
  - src_ptr increments; next state is WR.
- WR:
  - mem_addr=dst_ptr, mem_we=1;
  - mem_data=buf for copy, fill_val_r for fill;
  - at the edge, dst_ptr increments and count decrements;
  - if count was 1, go to FIN; else go to RD (copy) or stay in WR (fill).
- FIN: done=1 for exactly one cycle, then IDLE.
- Outputs are decoded from registered state and pointers only; there are no combinational paths from start to any mem_* output.
- Outside WR, mem_we=0. Outside RD and WR, mem_addr=0 and mem_data=0.
- Latency from the start cycle to the done cycle:
  - copy: 2*length+1 cycles;
  - fill: length+1 cycles;
  - length=0: 1 cycle, with no memory access.
- Pointers wrap modulo 2**ADDR_WIDTH; for example src=62, length=4 accesses 62, 63, 0, 1.
- length=2**ADDR_WIDTH is legal and touches every word exactly once.
- Overlap: copies run in ascending order, word by word. With dst>src inside the source range, already-written words are re-read (forward propagation). This is defined behaviour, not an error.
- start while busy or in FIN is ignored; there is no queueing.
- reset asserted mid-operation:
  - next cycle is IDLE with mem_we=0;
  - no done pulse;
  - the partial write stands, and at most the word in the current WR cycle is committed.

Decomposition:
- Shared header mem_engine_defs.vh holds:
  - state encoding localparams (IDLE=2'd0, RD=2'd1, WR=2'd2, FIN=2'd3);
  - OP_COPY/OP_FILL constants.
- No sub-module is required. A small addr_ptr counter (load/increment/wrap) may be factored out, but is not mandated.
- Bench instantiates the existing data memory with data.txt preloaded.

Test Plan:
- Copy: preload mem[0..3]=11,22,33,44; start with src=0, dst=16, len=4, op_fill=0 -> done pulses 9 cycles after start; mem[16..19]=11,22,33,44; mem[0..3] unchanged; mem_we high on exactly 4 cycles.
- Fill with wrap: dst=62, len=4, fill_val=A5 -> writes to 62, 63, 0, 1 in that order, all = A5; done 5 cycles after start; mem[2] untouched.
- Zero length: start with len=0 -> done on the next cycle; busy never asserts; mem_we stays 0.
- Overlapping copy: mem[8]=07, mem[9]=01; src=8, dst=9, len=3 -> mem[9..11]=07,07,07.
- Start while busy: second start with a different dst during a len=4 copy -> ignored; only the first destination is written; exactly one done pulse.
- Reset mid-op: assert reset during the 3rd WR of a len=8 fill -> next cycle busy=0, mem_we=0, no done; at most 3 words written; a new start afterwards completes normally.
